// File: rtl/vproc_bus_engine_if.sv
// vproc_bus_engine_if: command, write-data, response, bus and interrupt
// signals of the VProc bus engine. The master modport is the engine's own
// view; the slave modport is the view of the command source and bus slaves.
interface vproc_bus_engine_if #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int BURST_WIDTH = 12,
   parameter int TICK_WIDTH  = 16,
   parameter int INT_WIDTH   = 3
) ();
   // command channel
   logic                   CmdValid;
   logic                   CmdReady;
   logic [TICK_WIDTH-1:0]  CmdTicks;
   logic [ADDR_WIDTH-1:0]  CmdAddr;
   logic [DATA_WIDTH-1:0]  CmdData;
   logic                   CmdWE;
   logic                   CmdRD;
   logic [BURST_WIDTH-1:0] CmdBurst;

   // write-data stream for burst beats 2..N
   logic                   WrDataValid;
   logic                   WrDataReady;
   logic [DATA_WIDTH-1:0]  WrData;

   // response channel
   logic                   RspValid;
   logic [DATA_WIDTH-1:0]  RspData;
   logic                   RspLast;
   logic                   RspTimeout;
   logic                   RspErr;

   // VProc-style bus
   logic [ADDR_WIDTH-1:0]  Addr;
   logic                   WE;
   logic                   RD;
   logic [DATA_WIDTH-1:0]  DataOut;
   logic [DATA_WIDTH-1:0]  DataIn;
   logic                   WRAck;
   logic                   RDAck;
   logic [BURST_WIDTH-1:0] Burst;
   logic                   BurstFirst;
   logic                   BurstLast;

   // interrupt reporting and status
   logic [INT_WIDTH-1:0]   Interrupt;
   logic                   IrqValid;
   logic [INT_WIDTH-1:0]   IrqVector;
   logic                   Busy;

   modport master (
      input  CmdValid, CmdTicks, CmdAddr, CmdData, CmdWE, CmdRD, CmdBurst,
             WrDataValid, WrData, DataIn, WRAck, RDAck, Interrupt,
      output CmdReady, WrDataReady, RspValid, RspData, RspLast, RspTimeout,
             RspErr, Addr, WE, RD, DataOut, Burst, BurstFirst, BurstLast,
             IrqValid, IrqVector, Busy
   );

   modport slave (
      output CmdValid, CmdTicks, CmdAddr, CmdData, CmdWE, CmdRD, CmdBurst,
             WrDataValid, WrData, DataIn, WRAck, RDAck, Interrupt,
      input  CmdReady, WrDataReady, RspValid, RspData, RspLast, RspTimeout,
             RspErr, Addr, WE, RD, DataOut, Burst, BurstFirst, BurstLast,
             IrqValid, IrqVector, Busy
   );
endinterface

// File: rtl/vproc_bus_engine.sv
// vproc_bus_engine: executes {delay, read, write, burst} commands on the
// VProc Addr/WE/RD/DataOut/ack bus, returns read data and status on a
// response channel, and reports interrupt-vector changes.
module vproc_bus_engine #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int BURST_WIDTH     = 12,
   parameter int TICK_WIDTH      = 16,
   parameter int INT_WIDTH       = 3,
   parameter int BURST_ADDR_INCR = 1,
   parameter int TIMEOUT         = 0
) (
   input  logic               Clk,
   input  logic               Reset,
   vproc_bus_engine_if.master bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DELAY  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_STALL  = 2'd3;

   localparam logic [ADDR_WIDTH-1:0]  ADDR_INCR  = ADDR_WIDTH'(BURST_ADDR_INCR);
   localparam logic [BURST_WIDTH-1:0] BEAT_ONE   = BURST_WIDTH'(1);
   localparam logic [BURST_WIDTH-1:0] BEAT_TWO   = BURST_WIDTH'(2);
   localparam logic [TICK_WIDTH-1:0]  TICK_ONE   = TICK_WIDTH'(1);
   localparam bit                     TIMEOUT_EN = (TIMEOUT > 0);
   localparam logic [31:0]            WAIT_LAST  = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

   logic [1:0]             state;

   // command fields latched on accept
   logic [ADDR_WIDTH-1:0]  cmd_addr;
   logic [DATA_WIDTH-1:0]  cmd_data;
   logic                   cmd_we;
   logic                   cmd_rd;
   logic [BURST_WIDTH-1:0] cmd_burst;

   // progress counters
   logic [TICK_WIDTH-1:0]  tick_cnt;
   logic [BURST_WIDTH-1:0] beats_left;
   logic [31:0]            wait_cnt;

   // registered outputs
   logic                   cmd_ready;
   logic                   rsp_valid;
   logic [DATA_WIDTH-1:0]  rsp_data;
   logic                   rsp_last;
   logic                   rsp_timeout;
   logic                   rsp_err;
   logic [ADDR_WIDTH-1:0]  addr;
   logic                   we;
   logic                   rd;
   logic [DATA_WIDTH-1:0]  data_out;
   logic [BURST_WIDTH-1:0] burst;
   logic                   burst_first;
   logic                   burst_last;
   logic [INT_WIDTH-1:0]   irq_hist;
   logic                   irq_valid;
   logic [INT_WIDTH-1:0]   irq_vector;

   // decode of the current cycle
   logic                   cmd_accept;
   logic                   cmd_illegal;
   logic                   cmd_access;
   logic                   beat_ack;
   logic                   final_beat;
   logic                   wr_data_ready;
   logic                   ack_timeout;

   // first-beat values, taken from the live command or the latched one
   logic                   start_access;
   logic [ADDR_WIDTH-1:0]  start_addr;
   logic [DATA_WIDTH-1:0]  start_data;
   logic                   start_we;
   logic                   start_rd;
   logic [BURST_WIDTH-1:0] start_burst;
   logic [BURST_WIDTH-1:0] start_beats;

   assign cmd_accept    = (state == ST_IDLE) && cmd_ready && bus.CmdValid;
   assign cmd_illegal   = bus.CmdWE && bus.CmdRD;
   assign cmd_access    = bus.CmdWE ^ bus.CmdRD;
   // only an ack matching the driven strobe counts; STALL has both strobes low
   assign beat_ack      = (state == ST_ACCESS) && ((we && bus.WRAck) || (rd && bus.RDAck));
   assign final_beat    = (beats_left <= BEAT_ONE);
   assign wr_data_ready = (beat_ack && we && !final_beat) || (state == ST_STALL);
   assign ack_timeout   = TIMEOUT_EN && (state == ST_ACCESS) && !beat_ack && (wait_cnt == WAIT_LAST);

   // Select where the first bus beat comes from: IDLE uses the command inputs, DELAY the latched copy.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
      start_access = 1'b0;
      start_addr   = cmd_addr;
      start_data   = cmd_data;
      start_we     = cmd_we;
      start_rd     = cmd_rd;
      start_burst  = cmd_burst;
      if (state == ST_IDLE) begin
         start_addr   = bus.CmdAddr;
         start_data   = bus.CmdData;
         start_we     = bus.CmdWE;
         start_rd     = bus.CmdRD;
         start_burst  = bus.CmdBurst;
         start_access = cmd_accept && cmd_access && (bus.CmdTicks == '0);
      end else if (state == ST_DELAY) begin
         start_access = (tick_cnt == TICK_ONE) && (cmd_we || cmd_rd);
      end
      start_beats = (start_burst == '0) ? BEAT_ONE : start_burst;
   end

   // Command FSM: accept, delay, drive bus beats, stall on write data, respond.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= ST_IDLE;
         cmd_addr    <= '0;
         cmd_data    <= '0;
         cmd_we      <= 1'b0;
         cmd_rd      <= 1'b0;
         cmd_burst   <= '0;
         tick_cnt    <= '0;
         beats_left  <= '0;
         wait_cnt    <= '0;
         cmd_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_last    <= 1'b0;
         rsp_timeout <= 1'b0;
         rsp_err     <= 1'b0;
         addr        <= '0;
         we          <= 1'b0;
         rd          <= 1'b0;
         data_out    <= '0;
         burst       <= '0;
         burst_first <= 1'b0;
         burst_last  <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every branch below sees the pre-edge state and counters.
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_last    <= 1'b0;
         rsp_timeout <= 1'b0;
         rsp_err     <= 1'b0;

         case (state)
            ST_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_accept) begin
                  cmd_addr  <= bus.CmdAddr;
                  cmd_data  <= bus.CmdData;
                  cmd_we    <= bus.CmdWE;
                  cmd_rd    <= bus.CmdRD;
                  cmd_burst <= bus.CmdBurst;
                  if (cmd_illegal) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_last  <= 1'b1;
                  end else if (bus.CmdTicks != '0) begin
                     state     <= ST_DELAY;
                     tick_cnt  <= bus.CmdTicks;
                     cmd_ready <= 1'b0;
                  end else if (!cmd_access) begin
                     rsp_valid <= 1'b1;
                     rsp_last  <= 1'b1;
                  end
               end
            end

            ST_DELAY: begin
               tick_cnt <= tick_cnt - TICK_ONE;
               if ((tick_cnt == TICK_ONE) && !(cmd_we || cmd_rd)) begin
                  rsp_valid <= 1'b1;
                  rsp_last  <= 1'b1;
                  state     <= ST_IDLE;
                  cmd_ready <= 1'b1;
               end
            end

            ST_ACCESS: begin
               if (beat_ack) begin
                  addr        <= addr + ADDR_INCR;
                  beats_left  <= beats_left - BEAT_ONE;
                  wait_cnt    <= '0;
                  burst_first <= 1'b0;
                  burst_last  <= (beats_left == BEAT_TWO) && (burst > BEAT_ONE);
                  if (rd) begin
                     rsp_valid <= 1'b1;
                     rsp_data  <= bus.DataIn;
                     rsp_last  <= final_beat;
                  end
                  if (we && !final_beat) begin
                     if (bus.WrDataValid) begin
                        data_out <= bus.WrData;
                     end else begin
                        we    <= 1'b0;
                        state <= ST_STALL;
                     end
                  end
               end else if (TIMEOUT_EN) begin
                  wait_cnt <= wait_cnt + 32'd1;
               end
               // final ack or timeout both end the command and release the bus
               if ((beat_ack && final_beat) || ack_timeout) begin
                  rsp_valid   <= 1'b1;
                  rsp_last    <= 1'b1;
                  rsp_timeout <= ack_timeout;
                  we          <= 1'b0;
                  rd          <= 1'b0;
                  burst       <= '0;
                  burst_first <= 1'b0;
                  burst_last  <= 1'b0;
                  state       <= ST_IDLE;
                  cmd_ready   <= 1'b1;
               end
            end

            ST_STALL: begin
               if (bus.WrDataValid) begin
                  data_out <= bus.WrData;
                  we       <= 1'b1;
                  wait_cnt <= '0;
                  state    <= ST_ACCESS;
               end
            end

            default: state <= ST_IDLE;
         endcase

         // first beat of an access, from IDLE with no ticks or at the end of DELAY
         if (start_access) begin
            addr        <= start_addr;
            data_out    <= start_data;
            we          <= start_we;
            rd          <= start_rd;
            burst       <= start_burst;
            burst_first <= (start_burst > BEAT_ONE);
            burst_last  <= 1'b0;
            beats_left  <= start_beats;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b0;
            state       <= ST_ACCESS;
         end
      end
   end

   // Interrupt change detector, independent of the command FSM.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         irq_hist   <= '0;
         irq_valid  <= 1'b0;
         irq_vector <= '0;
      end else begin
         irq_hist  <= bus.Interrupt;
         irq_valid <= (bus.Interrupt != irq_hist);
         if (bus.Interrupt != irq_hist) begin
            irq_vector <= bus.Interrupt;
         end
      end
   end

   assign bus.CmdReady    = cmd_ready;
   assign bus.WrDataReady = wr_data_ready;
   assign bus.RspValid    = rsp_valid;
   assign bus.RspData     = rsp_data;
   assign bus.RspLast     = rsp_last;
   assign bus.RspTimeout  = rsp_timeout;
   assign bus.RspErr      = rsp_err;
   assign bus.Addr        = addr;
   assign bus.WE          = we;
   assign bus.RD          = rd;
   assign bus.DataOut     = data_out;
   assign bus.Burst       = burst;
   assign bus.BurstFirst  = burst_first;
   assign bus.BurstLast   = burst_last;
   assign bus.IrqValid    = irq_valid;
   assign bus.IrqVector   = irq_vector;
   assign bus.Busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_vproc_bus_engine.sv
// tb_vproc_bus_engine: directed self-checking bench for vproc_bus_engine
// with TIMEOUT=8; inputs change 1 ns after a rising edge and outputs are
// sampled at the same point.
module tb_vproc_bus_engine;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = 12;
   localparam int TW = 16;
   localparam int IW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   vproc_bus_engine_if #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW), .TICK_WIDTH(TW), .INT_WIDTH(IW)
   ) ifc ();

   vproc_bus_engine #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW), .TICK_WIDTH(TW), .INT_WIDTH(IW),
      .BURST_ADDR_INCR(1), .TIMEOUT(8)
   ) dut (
      .Clk  (clk),
      .Reset(rst),
      .bus  (ifc)
   );

   always #5 clk = ~clk;

   // advance to 1 ns after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // present one command and let it be accepted at the next edge
   task automatic send(input logic w, input logic r, input logic [TW-1:0] ticks,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] n);
      ifc.CmdValid = 1'b1;
      ifc.CmdWE    = w;
      ifc.CmdRD    = r;
      ifc.CmdTicks = ticks;
      ifc.CmdAddr  = a;
      ifc.CmdData  = d;
      ifc.CmdBurst = n;
      step();
      ifc.CmdValid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ifc.CmdValid    = 1'b0;
      ifc.CmdTicks    = '0;
      ifc.CmdAddr     = '0;
      ifc.CmdData     = '0;
      ifc.CmdWE       = 1'b0;
      ifc.CmdRD       = 1'b0;
      ifc.CmdBurst    = '0;
      ifc.WrDataValid = 1'b0;
      ifc.WrData      = '0;
      ifc.DataIn      = '0;
      ifc.WRAck       = 1'b0;
      ifc.RDAck       = 1'b0;
      ifc.Interrupt   = '0;

      // reset state
      step();
      step();
      check("rst_cmdready", ifc.CmdReady, 0);
      check("rst_busy", ifc.Busy, 0);
      check("rst_rspvalid", ifc.RspValid, 0);
      check("rst_irqvalid", ifc.IrqValid, 0);
      rst = 1'b0;
      step();
      check("post_rst_cmdready", ifc.CmdReady, 1);

      // reset while RD is high mid-burst
      send(1'b0, 1'b1, 16'd0, 32'h400, 32'h0, 12'd3);
      check("rb_rd", ifc.RD, 1);
      check("rb_addr", ifc.Addr, 32'h400);
      check("rb_burst", ifc.Burst, 3);
      check("rb_first", ifc.BurstFirst, 1);
      ifc.RDAck  = 1'b1;
      ifc.DataIn = 32'hCAFE0001;
      step();
      check("rb_beat1_valid", ifc.RspValid, 1);
      check("rb_beat1_data", ifc.RspData, 32'hCAFE0001);
      check("rb_beat1_last", ifc.RspLast, 0);
      check("rb_beat1_addr", ifc.Addr, 32'h401);
      check("rb_beat1_first", ifc.BurstFirst, 0);
      check("rb_beat1_rd", ifc.RD, 1);
      ifc.RDAck = 1'b0;
      rst = 1'b1;
      #1;
      check("rb_async_rd", ifc.RD, 0);
      check("rb_async_addr", ifc.Addr, 0);
      check("rb_async_rspvalid", ifc.RspValid, 0);
      check("rb_async_burst", ifc.Burst, 0);
      check("rb_async_busy", ifc.Busy, 0);
      check("rb_async_cmdready", ifc.CmdReady, 0);
      step();
      step();
      rst = 1'b0;
      step();
      check("rb_rel_cmdready", ifc.CmdReady, 1);
      check("rb_rel_rspvalid", ifc.RspValid, 0);
      step();
      check("rb_rel_rspvalid2", ifc.RspValid, 0);

      // single read, two wait cycles; a wrong-type ack in between is ignored
      send(1'b0, 1'b1, 16'd0, 32'h100, 32'h0, 12'd0);
      check("rd_rd_c1", ifc.RD, 1);
      check("rd_addr", ifc.Addr, 32'h100);
      check("rd_cmdready", ifc.CmdReady, 0);
      check("rd_first", ifc.BurstFirst, 0);
      step();
      check("rd_rd_c2", ifc.RD, 1);
      ifc.WRAck = 1'b1;
      step();
      check("rd_rd_c3", ifc.RD, 1);
      check("rd_wrongack_novalid", ifc.RspValid, 0);
      ifc.WRAck  = 1'b0;
      ifc.RDAck  = 1'b1;
      ifc.DataIn = 32'hDEADBEEF;
      step();
      ifc.RDAck = 1'b0;
      check("rd_rspvalid", ifc.RspValid, 1);
      check("rd_rspdata", ifc.RspData, 32'hDEADBEEF);
      check("rd_rsplast", ifc.RspLast, 1);
      check("rd_rd_off", ifc.RD, 0);
      check("rd_cmdready_back", ifc.CmdReady, 1);
      step();
      check("rd_single_pulse", ifc.RspValid, 0);

      // write burst of 4 with write data withheld for 2 cycles before beat 3
      ifc.WrDataValid = 1'b1;
      ifc.WrData      = 32'hA1;
      send(1'b1, 1'b0, 16'd0, 32'h10, 32'hA0, 12'd4);
      check("wb_b1_we", ifc.WE, 1);
      check("wb_b1_addr", ifc.Addr, 32'h10);
      check("wb_b1_data", ifc.DataOut, 32'hA0);
      check("wb_b1_first", ifc.BurstFirst, 1);
      check("wb_b1_last", ifc.BurstLast, 0);
      ifc.WRAck = 1'b1;
      #1;
      check("wb_b1_wrready", ifc.WrDataReady, 1);
      step();
      check("wb_b2_addr", ifc.Addr, 32'h11);
      check("wb_b2_data", ifc.DataOut, 32'hA1);
      check("wb_b2_first", ifc.BurstFirst, 0);
      check("wb_b2_last", ifc.BurstLast, 0);
      check("wb_b2_novalid", ifc.RspValid, 0);
      ifc.WrDataValid = 1'b0;
      ifc.WrData      = 32'hA2;
      step();
      check("wb_stall1_we", ifc.WE, 0);
      check("wb_stall1_addr", ifc.Addr, 32'h12);
      check("wb_stall1_wrready", ifc.WrDataReady, 1);
      step();
      check("wb_stall2_we", ifc.WE, 0);
      check("wb_stall2_addr", ifc.Addr, 32'h12);
      ifc.WrDataValid = 1'b1;
      step();
      check("wb_b3_we", ifc.WE, 1);
      check("wb_b3_addr", ifc.Addr, 32'h12);
      check("wb_b3_data", ifc.DataOut, 32'hA2);
      check("wb_b3_last", ifc.BurstLast, 0);
      ifc.WrData = 32'hA3;
      step();
      check("wb_b4_addr", ifc.Addr, 32'h13);
      check("wb_b4_data", ifc.DataOut, 32'hA3);
      check("wb_b4_last", ifc.BurstLast, 1);
      check("wb_b4_novalid", ifc.RspValid, 0);
      ifc.WrDataValid = 1'b0;
      step();
      ifc.WRAck = 1'b0;
      check("wb_done_valid", ifc.RspValid, 1);
      check("wb_done_last", ifc.RspLast, 1);
      check("wb_done_we", ifc.WE, 0);
      check("wb_done_cmdready", ifc.CmdReady, 1);
      step();
      check("wb_single_pulse", ifc.RspValid, 0);

      // write with no ack times out after 8 cycles
      send(1'b1, 1'b0, 16'd0, 32'h200, 32'h55, 12'd1);
      check("to_we_start", ifc.WE, 1);
      repeat (7) step();
      check("to_we_c8", ifc.WE, 1);
      check("to_novalid_c8", ifc.RspValid, 0);
      step();
      check("to_we_drop", ifc.WE, 0);
      check("to_valid", ifc.RspValid, 1);
      check("to_timeout", ifc.RspTimeout, 1);
      check("to_last", ifc.RspLast, 1);
      check("to_err", ifc.RspErr, 0);

      // illegal command: error pulse, no bus activity
      step();
      send(1'b1, 1'b1, 16'd0, 32'h500, 32'h0, 12'd0);
      check("err_valid", ifc.RspValid, 1);
      check("err_err", ifc.RspErr, 1);
      check("err_last", ifc.RspLast, 1);
      check("err_we", ifc.WE, 0);
      check("err_rd", ifc.RD, 0);
      check("err_cmdready", ifc.CmdReady, 1);
      step();
      check("err_single_pulse", ifc.RspValid, 0);
      check("err_rd_after", ifc.RD, 0);

      // pure delay of 5 ticks: response exactly 5 cycles after accept
      send(1'b0, 1'b0, 16'd5, 32'h0, 32'h0, 12'd0);
      check("dly_cmdready", ifc.CmdReady, 0);
      check("dly_busy", ifc.Busy, 1);
      check("dly_novalid0", ifc.RspValid, 0);
      repeat (4) step();
      check("dly_novalid4", ifc.RspValid, 0);
      step();
      check("dly_valid5", ifc.RspValid, 1);
      check("dly_last5", ifc.RspLast, 1);
      check("dly_err5", ifc.RspErr, 0);
      check("dly_idle5", ifc.Busy, 0);

      // read after 2 ticks; an ack already high is ignored while RD is low
      ifc.RDAck  = 1'b1;
      ifc.DataIn = 32'h12345678;
      send(1'b0, 1'b1, 16'd2, 32'h300, 32'h0, 12'd1);
      check("dr_rd_t0", ifc.RD, 0);
      step();
      check("dr_rd_t1", ifc.RD, 0);
      check("dr_novalid_t1", ifc.RspValid, 0);
      step();
      check("dr_rd_t2", ifc.RD, 1);
      check("dr_addr_t2", ifc.Addr, 32'h300);
      step();
      ifc.RDAck = 1'b0;
      check("dr_valid", ifc.RspValid, 1);
      check("dr_data", ifc.RspData, 32'h12345678);
      check("dr_rd_off", ifc.RD, 0);

      // interrupt changes 0 -> 5 -> 5 -> 2
      ifc.Interrupt = 3'd5;
      step();
      check("irq1_valid", ifc.IrqValid, 1);
      check("irq1_vector", ifc.IrqVector, 5);
      step();
      check("irq_hold_valid_a", ifc.IrqValid, 0);
      step();
      check("irq_hold_valid_b", ifc.IrqValid, 0);
      ifc.Interrupt = 3'd2;
      step();
      check("irq2_valid", ifc.IrqValid, 1);
      check("irq2_vector", ifc.IrqVector, 2);
      step();
      check("irq2_single_pulse", ifc.IrqValid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
